vga_tile_painter: RTL and testbench

VGA_TILE_PAINTER -- requirements
Module: vga_tile_painter

---
 rtl/vga_tile_pkg.sv | 22 ++
 rtl/pixel_tick_gen.sv | 32 +++
 rtl/vga_tile_painter.sv | 193 +++++++++++++++++++
 tb/tb_vga_tile_painter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_tile_pkg.sv
// vga_tile_pkg: shared colour type, gray level and power-up palette for the tile painter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_tile_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [7:0] GRAY_LEVEL = 8'h10;

  // Index 0 is the rightmost element: red, green, blue, white.
  localparam logic [3:0][23:0] DEFAULT_PAL = {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000};

  // Reset value of palette entry idx; the 4-entry default repeats for larger palettes.
  function automatic rgb_t default_entry(input int idx);
    return rgb_t'(DEFAULT_PAL[2'(idx % 4)]);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: one-cycle tick every DIV FPGA_Clock cycles (pixel-rate enable).
// Latency: first tick DIV cycles after reset deasserts; tick is decoded from the counter.
// Backpressure: none; free-running.  Ports: FPGA_Clock, reset (sync, active-high), tick.
module pixel_tick_gen #(
  parameter int DIV = 2
) (
  input  logic FPGA_Clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter sits at 0 after reset, so the DIV-th edge after release is the first tick edge.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge FPGA_Clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_tile_painter.sv
// vga_tile_painter: paints the visible area as a COLSxROWS grid of palette colours with a blinking highlight.
// Latency: two pixel ticks from h_count/v_count to R/G/B/tile/active; palette writes act on any clock edge.
// Backpressure: none; inputs are sampled on each tick.  Ports: FPGA_Clock, reset, enable, h/v_count, sel_*, pal_*, R/G/B, tile, active.
module vga_tile_painter
  import vga_tile_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int COLS         = 2,
  parameter int ROWS         = 2,
  parameter int DIV          = 2,
  parameter int BLINK_FRAMES = 30,
  localparam int TILES       = COLS * ROWS,
  localparam int TW          = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic          FPGA_Clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [9:0]    h_count,
  input  logic [9:0]    v_count,
  input  logic          sel_valid,
  input  logic [TW-1:0] sel_tile,
  input  logic          pal_we,
  input  logic [TW-1:0] pal_addr,
  input  logic [23:0]   pal_data,
  output logic [7:0]    R,
  output logic [7:0]    G,
  output logic [7:0]    B,
  output logic [TW-1:0] tile,
  output logic          active
);

  localparam int TILE_W = H_ACTIVE / COLS;
  localparam int TILE_H = V_ACTIVE / ROWS;
  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

  logic tick;

  pixel_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .FPGA_Clock(FPGA_Clock),
    .reset     (reset),
    .tick      (tick)
  );

  // Palette register array
  rgb_t pal_q [TILES];
  rgb_t pal_d [TILES];

  // Stage 1
  logic [TW-1:0] s1_tile_q, s1_tile_d;
  logic          s1_vis_q, s1_vis_d;
  logic          s1_en_q, s1_en_d;
  logic          s1_hl_q, s1_hl_d;
  rgb_t          s1_pal_q, s1_pal_d;

  // Stage 2 / outputs
  rgb_t          rgb_q, rgb_d;
  logic [TW-1:0] tile_q, tile_d;
  logic          active_q, active_d;

  // Blink timing
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d;

  // Combinational pixel decode
  logic [TW-1:0] col;
  logic [TW-1:0] row_base;
  logic [TW-1:0] pix_tile;
  logic          pix_vis;
  rgb_t          pal_rd;

  // Tile column/row found by comparing against fixed boundaries; the last
  // boundary crossed wins, so no divider is needed.  Off-screen coordinates
  // land in the last column/row, which is harmless because they are not visible.
  always_comb begin
    col      = '0;
    row_base = '0;
    for (int c = 1; c < COLS; c++) begin
      if (h_count >= 10'(c * TILE_W)) col = TW'(c);
    end
    for (int r = 1; r < ROWS; r++) begin
      if (v_count >= 10'(r * TILE_H)) row_base = TW'(r * COLS);
    end
    pix_tile = row_base + col;
    pix_vis  = (h_count < H_LIM) && (v_count < V_LIM);
    // Read mux sees the pre-edge palette, so a same-edge write returns the old entry.
    pal_rd   = '0;
    for (int i = 0; i < TILES; i++) begin
      if (pix_tile == TW'(i)) pal_rd = pal_q[i];
    end
  end

  // Palette writes ignore the tick; addresses without a matching entry fall through.
  always_comb begin
    for (int i = 0; i < TILES; i++) begin
      pal_d[i] = pal_q[i];
      if (pal_we && (pal_addr == TW'(i))) pal_d[i] = rgb_t'(pal_data);
    end
  end

  // Stage 1: capture decode, palette read and control inputs on a tick.
  always_comb begin
    s1_tile_d = s1_tile_q;
    s1_vis_d  = s1_vis_q;
    s1_en_d   = s1_en_q;
    s1_hl_d   = s1_hl_q;
    s1_pal_d  = s1_pal_q;
    if (tick) begin
      s1_tile_d = pix_tile;
      s1_vis_d  = pix_vis;
      s1_en_d   = enable;
      s1_pal_d  = pal_rd;
      // pix_tile never reaches TILES, so an out-of-range sel_tile cannot match.
      s1_hl_d   = sel_valid && (sel_tile == pix_tile) && blink_q;
    end
  end

  // Frame counter advances at the frame origin; the blink phase flips every BLINK_FRAMES frames.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (tick && (h_count == '0) && (v_count == '0)) begin
      if (frame_cnt_q == FLAST) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Stage 2: colour select.  Tile output holds through blanking.
  always_comb begin
    rgb_d    = rgb_q;
    tile_d   = tile_q;
    active_d = active_q;
    if (tick) begin
      active_d = s1_vis_q;
      if (s1_vis_q) begin
        tile_d = s1_tile_q;
        if (!s1_en_q) begin
          rgb_d = rgb_t'({GRAY_LEVEL, GRAY_LEVEL, GRAY_LEVEL});
        end else if (s1_hl_q) begin
          rgb_d = ~s1_pal_q;
        end else begin
          rgb_d = s1_pal_q;
        end
      end else begin
        rgb_d = '0;
      end
    end
  end

  always_ff @(posedge FPGA_Clock) begin
    if (reset) begin
      s1_tile_q   <= '0;
      s1_vis_q    <= 1'b0;
      s1_en_q     <= 1'b0;
      s1_hl_q     <= 1'b0;
      s1_pal_q    <= '0;
      rgb_q       <= '0;
      tile_q      <= '0;
      active_q    <= 1'b0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      for (int i = 0; i < TILES; i++) pal_q[i] <= default_entry(i);
    end else begin
      s1_tile_q   <= s1_tile_d;
      s1_vis_q    <= s1_vis_d;
      s1_en_q     <= s1_en_d;
      s1_hl_q     <= s1_hl_d;
      s1_pal_q    <= s1_pal_d;
      rgb_q       <= rgb_d;
      tile_q      <= tile_d;
      active_q    <= active_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      for (int i = 0; i < TILES; i++) pal_q[i] <= pal_d[i];
    end
  end

  assign R      = rgb_q.r;
  assign G      = rgb_q.g;
  assign B      = rgb_q.b;
  assign tile   = tile_q;
  assign active = active_q;

endmodule

// File: tb/tb_vga_tile_painter.sv
// tb_vga_tile_painter: scoreboard bench for vga_tile_painter (4x2 tiles, DIV=2, 2-frame blink).
// Latency: expectations are queued at issue and popped by a monitor on every pixel tick.
// Backpressure: none; the monitor also checks outputs stay put between ticks.
module tb_vga_tile_painter;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int DIV   = 2;
  localparam int BF    = 2;
  localparam int TILES = COLS * ROWS;

  typedef struct {
    logic [23:0] rgb;
    logic [2:0]  tile;
    logic        active;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [9:0]  h_count = '0;
  logic [9:0]  v_count = '0;
  logic        sel_valid = 1'b0;
  logic [2:0]  sel_tile = '0;
  logic        pal_we = 1'b0;
  logic [2:0]  pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic [7:0]  R, G, B;
  logic [2:0]  tile_o;
  logic        active;

  int checks = 0;
  int failures = 0;

  exp_t expq[$];
  exp_t last_exp;
  logic [23:0] mpal [TILES];
  logic [23:0] dflt [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
  int frame_starts;
  int last_tile;

  vga_tile_painter #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .COLS(COLS), .ROWS(ROWS),
    .DIV(DIV), .BLINK_FRAMES(BF)
  ) dut (
    .FPGA_Clock(clk),
    .reset     (reset),
    .enable    (enable),
    .h_count   (h_count),
    .v_count   (v_count),
    .sel_valid (sel_valid),
    .sel_tile  (sel_tile),
    .pal_we    (pal_we),
    .pal_addr  (pal_addr),
    .pal_data  (pal_data),
    .R         (R),
    .G         (G),
    .B         (B),
    .tile      (tile_o),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string name, input exp_t e);
    checks++;
    if ({R, G, B} !== e.rgb || tile_o !== e.tile || active !== e.active) begin
      failures++;
      $display("FAIL %s t=%0t actual rgb=%06h tile=%0d active=%0b required rgb=%06h tile=%0d active=%0b",
               name, $time, {R, G, B}, tile_o, active, e.rgb, e.tile, e.active);
    end
  endtask

  // Monitor: tracks pixel ticks from reset release on its own.
  initial begin : monitor
    int   mcyc;
    logic rst_seen;
    exp_t zero_e;
    zero_e = '{rgb: 24'h0, tile: 3'd0, active: 1'b0};
    mcyc = 0;
    last_exp = zero_e;
    forever begin
      @(posedge clk);
      rst_seen = reset;
      #1;
      if (rst_seen) begin
        mcyc = 0;
        last_exp = zero_e;
        check_out("reset_outputs", zero_e);
      end else begin
        mcyc++;
        if (mcyc % DIV == 0) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL queue_empty t=%0t actual size=0 required size>0", $time);
          end else begin
            last_exp = expq.pop_front();
            check_out("pixel", last_exp);
          end
        end else begin
          check_out("hold_between_ticks", last_exp);
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < TILES; i++) mpal[i] = dflt[i % 4];
    frame_starts = 0;
    last_tile = 0;
  endtask

  // Reset while pal_we is asserted: the write must lose to reset.
  task automatic apply_reset(input int n);
    exp_t bubble;
    #2;
    reset = 1'b1;
    pal_we = 1'b1;
    pal_addr = 3'd1;
    pal_data = 24'hABCDEF;
    expq.delete();
    model_reset();
    bubble = '{rgb: 24'h0, tile: 3'd0, active: 1'b0};
    expq.push_back(bubble);
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    pal_we = 1'b0;
  endtask

  // One pixel, held for DIV clocks; optional palette write on clock wcyc of that pixel.
  task automatic drive_pixel(input int h, input int v, input bit en, input bit sv, input int st,
                             input bit we, input int waddr, input logic [23:0] wdata, input int wcyc);
    exp_t e;
    bit   vis;
    bit   blink;
    int   t;
    if (we && wcyc < DIV - 1 && waddr < TILES) mpal[waddr] = wdata;
    vis   = (h < H_ACT) && (v < V_ACT);
    blink = ((frame_starts / BF) % 2) == 1;
    if (vis) begin
      t = (v / (V_ACT / ROWS)) * COLS + h / (H_ACT / COLS);
      last_tile = t;
      if (!en) e.rgb = 24'h101010;
      else if (sv && st == t && blink) e.rgb = ~mpal[t];
      else e.rgb = mpal[t];
      e.active = 1'b1;
    end else begin
      e.rgb = 24'h0;
      e.active = 1'b0;
    end
    e.tile = 3'(last_tile);
    if (h == 0 && v == 0) frame_starts++;
    if (we && wcyc == DIV - 1 && waddr < TILES) mpal[waddr] = wdata;
    expq.push_back(e);
    h_count = 10'(h);
    v_count = 10'(v);
    enable = en;
    sel_valid = sv;
    sel_tile = 3'(st);
    for (int c = 0; c < DIV; c++) begin
      pal_we = we && (c == wcyc);
      pal_addr = 3'(waddr);
      pal_data = wdata;
      @(posedge clk);
      #1;
    end
    pal_we = 1'b0;
  endtask

  task automatic write_then_reset(input int waddr, input logic [23:0] wdata);
    h_count = 10'd5;
    v_count = 10'd5;
    pal_we = 1'b1;
    pal_addr = 3'(waddr);
    pal_data = wdata;
    @(posedge clk);
    #1;
    pal_we = 1'b0;
    mpal[waddr] = wdata;
    apply_reset(3);
  endtask

  initial begin : stimulus
    int h, v;
    model_reset();
    apply_reset(3);

    // Basic decode and palette colours
    drive_pixel(320, 100, 1, 0, 0, 0, 0, 24'h0, 0);
    drive_pixel(479, 239, 1, 0, 0, 0, 0, 24'h0, 0);
    drive_pixel(480, 240, 1, 0, 0, 0, 0, 24'h0, 0);
    drive_pixel(0, 479, 1, 0, 0, 0, 0, 24'h0, 0);
    // Same-edge write/read of tile 3, then the new value
    drive_pixel(480, 0, 1, 0, 0, 1, 3, 24'h123456, DIV - 1);
    drive_pixel(500, 0, 1, 0, 0, 0, 0, 24'h0, 0);
    // Write on a non-tick edge is visible to the read at the following tick
    drive_pixel(10, 300, 1, 0, 0, 1, 4, 24'h0A0B0C, 0);
    // Gray and blanking, tile held through blanking
    drive_pixel(10, 10, 0, 1, 0, 0, 0, 24'h0, 0);
    drive_pixel(700, 10, 0, 0, 0, 0, 0, 24'h0, 0);
    drive_pixel(10, 500, 1, 0, 0, 0, 0, 24'h0, 0);

    // Blink: four frames of highlighted tile 0
    apply_reset(2);
    for (int f = 0; f < 4; f++) begin
      drive_pixel(10, 10, 1, 1, 0, 0, 0, 24'h0, 0);
      drive_pixel(0, 0, 1, 0, 0, 0, 0, 24'h0, 0);
    end

    // Reset mid-line after a write restores defaults
    write_then_reset(0, 24'h5A5A5A);
    drive_pixel(10, 10, 1, 0, 0, 0, 0, 24'h0, 0);
    drive_pixel(200, 10, 1, 0, 0, 0, 0, 24'h0, 0);

    // Randomised pixels, frame origins, highlights and palette writes
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        h = 0;
        v = 0;
      end else begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
      end
      drive_pixel(h, v, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, TILES - 1), $urandom_range(0, 2) == 0,
                  $urandom_range(0, TILES - 1), 24'($urandom), $urandom_range(0, DIV - 1));
    end

    // Flush the last real pixel through stage 2
    drive_pixel(700, 500, 1, 0, 0, 0, 0, 24'h0, 0);
    repeat (2) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
